centroid_div_sched: RTL and testbench

CENTROID_DIV_SCHED -- requirements
Module: centroid_div_sched

---
 rtl/centroid_div_sched_pkg.sv | 24 ++
 rtl/centroid_div_sched_tag_pipe.sv | 54 +++++
 rtl/centroid_div_sched.sv | 182 ++++++++++++++++++
 tb/tb_centroid_div_sched.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/centroid_div_sched_pkg.sv
// Shared types and defaults for the centroid divide scheduler.
package centroid_div_sched_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  localparam int K_DEF       = 4;
  localparam int D_DEF       = 2;
  localparam int SUM_W_DEF   = 20;
  localparam int CNT_W_DEF   = 12;
  localparam int DIV_LAT_DEF = 24;

  // Index width that never collapses to zero bits.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int IDX_W_DEF = idx_w(K_DEF * D_DEF);

endpackage

// File: rtl/centroid_div_sched_tag_pipe.sv
// cds_tag_pipe: fixed-depth delay line for per-slot tags, advanced every
// cycle so that it stays aligned with an external fixed-latency divider.
module cds_tag_pipe #(
  parameter int DEPTH = 24,
  parameter int W     = 4
) (
  input  logic         clk,
  input  logic         sclr,
  input  logic         in_vld,
  input  logic [W-1:0] in_data,
  output logic         out_vld,
  output logic [W-1:0] out_data,
  output logic         tail_only
);

  logic [DEPTH-1:0]        vld_d, vld_q;
  logic [DEPTH-1:0][W-1:0] dat_d, dat_q;

  // Shift one stage per cycle; stage 0 takes the new slot.
  always_comb begin
    vld_d    = '0;
    dat_d    = '0;
    vld_d[0] = in_vld;
    dat_d[0] = in_data;
    for (int i = 1; i < DEPTH; i++) begin
      vld_d[i] = vld_q[i-1];
      dat_d[i] = dat_q[i-1];
    end
  end

  // Pipe registers; reset empties every slot so in-flight results are dropped.
  always_ff @(posedge clk or posedge sclr) begin
    if (sclr) begin
      vld_q <= '0;
      dat_q <= '0;
    end else begin
      vld_q <= vld_d;
      dat_q <= dat_d;
    end
  end

  // True when nothing but (possibly) the output stage is occupied, i.e. the
  // pipe will be empty after this edge if no new slot enters.
  always_comb begin
    tail_only = 1'b1;
    for (int i = 0; i < DEPTH - 1; i++) begin
      if (vld_q[i]) tail_only = 1'b0;
    end
  end

  assign out_vld  = vld_q[DEPTH-1];
  assign out_data = dat_q[DEPTH-1];

endmodule

// File: rtl/centroid_div_sched.sv
// centroid_div_sched: walks every (cluster, dim) element once per pass, feeds
// sum/count to an external fixed-latency divider and writes the quotients
// back as new centroid coordinates. Empty clusters keep their old centroid.
// Optional: define CENTROID_DIV_ROUND_EN for round-half-up results.
module centroid_div_sched
  import centroid_div_sched_pkg::*;
#(
  parameter int K       = K_DEF,
  parameter int D       = D_DEF,
  parameter int SUM_W   = SUM_W_DEF,
  parameter int CNT_W   = CNT_W_DEF,
  parameter int DIV_LAT = DIV_LAT_DEF
) (
  input  logic                       clk,
  input  logic                       sclr,
  input  logic                       start,
  output logic                       busy,
  output logic                       done,
  output logic [idx_w(K+1)-1:0]      empty_cnt,
  output logic [idx_w(K*D)-1:0]      rd_idx,
  input  logic [SUM_W-1:0]           sum_data,
  input  logic [CNT_W-1:0]           cnt_data,
  output logic [SUM_W-1:0]           div_dividend,
  output logic [CNT_W-1:0]           div_divisor,
  output logic                       div_nd,
  input  logic [SUM_W-1:0]           div_quotient,
  input  logic [CNT_W-1:0]           div_fractional,
  output logic                       cen_we,
  output logic [idx_w(K*D)-1:0]      cen_waddr,
  output logic [SUM_W-1:0]           cen_wdata
);

  localparam int N     = K * D;
  localparam int IDX_W = idx_w(N);
  localparam int EC_W  = idx_w(K + 1);
  localparam int DIM_W = idx_w(D);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);
  localparam logic [DIM_W-1:0] LAST_DIM = DIM_W'(D - 1);
`ifdef CENTROID_DIV_ROUND_EN
  localparam int TAG_W = 1 + IDX_W + CNT_W;
`else
  localparam int TAG_W = 1 + IDX_W;
`endif

  state_e             state_q;
  logic               busy_q, done_q;
  logic [IDX_W-1:0]   rd_idx_d, rd_idx_q;
  logic [DIM_W-1:0]   rd_dim_d, rd_dim_q;
  logic               iss_vld_d, iss_vld_q;
  logic [IDX_W-1:0]   iss_idx_d, iss_idx_q;
  logic               iss_dim0_d, iss_dim0_q;
  logic [EC_W-1:0]    empty_cnt_d, empty_cnt_q;
  logic               cnt_zero;
  logic [TAG_W-1:0]   tag_in, tag_out;
  logic               tag_vld, tag_wr, tail_only;
  logic [IDX_W-1:0]   tag_idx;
  logic [SUM_W-1:0]   result;

  // Control FSM: run the issue walk, wait for the tag pipe to drain, pulse done.
  always_ff @(posedge clk or posedge sclr) begin
    if (sclr) begin
      state_q <= S_IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        S_IDLE:  if (start) begin
                   state_q <= S_ISSUE;
                   busy_q  <= 1'b1;
                 end
        S_ISSUE: if (rd_idx_q == LAST_IDX) state_q <= S_DRAIN;
        S_DRAIN: if (!iss_vld_q && tail_only) begin
                   state_q <= S_DONE;
                   done_q  <= 1'b1;
                 end
        S_DONE:  begin
                   state_q <= S_IDLE;
                   busy_q  <= 1'b0;
                 end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign cnt_zero = (cnt_data == '0);

  // Read-address walk and issue-stage bookkeeping; memory data arrives one
  // cycle after rd_idx, so the issue stage is the address delayed by one.
  always_comb begin
    rd_idx_d    = rd_idx_q;
    rd_dim_d    = rd_dim_q;
    iss_vld_d   = 1'b0;
    iss_idx_d   = rd_idx_q;
    iss_dim0_d  = (rd_dim_q == '0);
    empty_cnt_d = empty_cnt_q;
    if (state_q == S_IDLE) begin
      if (start) begin
        rd_idx_d    = '0;
        rd_dim_d    = '0;
        empty_cnt_d = '0;
      end
    end else if (state_q == S_ISSUE) begin
      iss_vld_d = 1'b1;
      if (rd_idx_q == LAST_IDX) begin
        rd_idx_d = '0;
        rd_dim_d = '0;
      end else begin
        rd_idx_d = rd_idx_q + IDX_W'(1);
        rd_dim_d = (rd_dim_q == LAST_DIM) ? '0 : rd_dim_q + DIM_W'(1);
      end
    end
    // Each cluster counted once, on its dim-0 element.
    if (iss_vld_q && iss_dim0_q && cnt_zero)
      empty_cnt_d = empty_cnt_q + EC_W'(1);
  end

  // Datapath registers.
  always_ff @(posedge clk or posedge sclr) begin
    if (sclr) begin
      rd_idx_q    <= '0;
      rd_dim_q    <= '0;
      iss_vld_q   <= 1'b0;
      iss_idx_q   <= '0;
      iss_dim0_q  <= 1'b0;
      empty_cnt_q <= '0;
    end else begin
      rd_idx_q    <= rd_idx_d;
      rd_dim_q    <= rd_dim_d;
      iss_vld_q   <= iss_vld_d;
      iss_idx_q   <= iss_idx_d;
      iss_dim0_q  <= iss_dim0_d;
      empty_cnt_q <= empty_cnt_d;
    end
  end

  // Divider operands; an empty cluster still consumes a slot but never
  // presents a zero divisor.
  assign div_nd       = iss_vld_q & ~cnt_zero;
  assign div_dividend = iss_vld_q ? sum_data : '0;
  assign div_divisor  = div_nd ? cnt_data : CNT_W'(1);

`ifdef CENTROID_DIV_ROUND_EN
  logic [CNT_W-1:0] tag_div;
  logic [CNT_W:0]   frac2;
  logic             round_up;
  assign tag_in = {div_nd, iss_idx_q, div_divisor};
  assign {tag_wr, tag_idx, tag_div} = tag_out;
  assign frac2    = {div_fractional, 1'b0};
  assign round_up = (frac2 >= {1'b0, tag_div}) && !(&div_quotient);
  assign result   = div_quotient + SUM_W'(round_up);
`else
  logic unused_frac;
  assign tag_in = {div_nd, iss_idx_q};
  assign {tag_wr, tag_idx} = tag_out;
  assign unused_frac = ^div_fractional;
  assign result = div_quotient;
`endif

  cds_tag_pipe #(
    .DEPTH (DIV_LAT),
    .W     (TAG_W)
  ) u_tag_pipe (
    .clk       (clk),
    .sclr      (sclr),
    .in_vld    (iss_vld_q),
    .in_data   (tag_in),
    .out_vld   (tag_vld),
    .out_data  (tag_out),
    .tail_only (tail_only)
  );

  assign cen_we    = tag_vld & tag_wr;
  assign cen_waddr = cen_we ? tag_idx : '0;
  assign cen_wdata = cen_we ? result : '0;

  assign busy      = busy_q;
  assign done      = done_q;
  assign rd_idx    = rd_idx_q;
  assign empty_cnt = empty_cnt_q;

endmodule

// File: tb/tb_centroid_div_sched.sv
// Self-checking bench for centroid_div_sched with a memory model, a
// fixed-latency divider model and an arithmetic reference of the results.
module tb_centroid_div_sched;

  localparam int K   = 4;
  localparam int D   = 2;
  localparam int N   = K * D;
  localparam int LAT = 24;
  localparam int SW  = 20;
  localparam int CW  = 12;
  localparam int DONE_CYC = N + 2 + LAT;
  localparam int PASS_CYC = DONE_CYC + 4;
`ifdef CENTROID_DIV_ROUND_EN
  localparam bit ROUND = 1'b1;
`else
  localparam bit ROUND = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          sclr, start, busy, done;
  logic [2:0]    empty_cnt, rd_idx, cen_waddr;
  logic [SW-1:0] sum_data, div_dividend, div_quotient, cen_wdata;
  logic [CW-1:0] cnt_data, div_divisor, div_fractional;
  logic          div_nd, cen_we;

  centroid_div_sched #(.K(K), .D(D), .SUM_W(SW), .CNT_W(CW), .DIV_LAT(LAT)) dut (
    .clk(clk), .sclr(sclr), .start(start), .busy(busy), .done(done),
    .empty_cnt(empty_cnt), .rd_idx(rd_idx), .sum_data(sum_data), .cnt_data(cnt_data),
    .div_dividend(div_dividend), .div_divisor(div_divisor), .div_nd(div_nd),
    .div_quotient(div_quotient), .div_fractional(div_fractional),
    .cen_we(cen_we), .cen_waddr(cen_waddr), .cen_wdata(cen_wdata));

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Sum/count memory with one-cycle read latency.
  logic [SW-1:0] sums [N];
  logic [CW-1:0] cnts [K];
  always @(posedge clk) begin
    sum_data <= sums[rd_idx];
    cnt_data <= cnts[rd_idx / D];
  end

  // External divider: result appears LAT cycles after the operands.
  logic [SW-1:0] dq [LAT];
  logic [CW-1:0] dr [LAT];
  always @(posedge clk) begin
    for (int i = LAT - 1; i > 0; i--) begin
      dq[i] <= dq[i-1];
      dr[i] <= dr[i-1];
    end
    if (div_divisor != '0) begin
      dq[0] <= div_dividend / SW'(div_divisor);
      dr[0] <= CW'(div_dividend % SW'(div_divisor));
    end else begin
      dq[0] <= '0;
      dr[0] <= '0;
    end
  end
  assign div_quotient   = dq[LAT-1];
  assign div_fractional = dr[LAT-1];

  // Monitor: log writes, done pulses and div_nd by cycle relative to start.
  int base = 0;
  int mon_r;
  int wr_c[$], wr_a[$], done_c[$];
  logic [SW-1:0] wr_d[$];
  logic nd_log [64];
  always @(negedge clk) begin
    mon_r = cyc - base;
    if (cen_we === 1'b1) begin
      wr_c.push_back(mon_r);
      wr_a.push_back(int'(cen_waddr));
      wr_d.push_back(cen_wdata);
    end
    if (done === 1'b1) done_c.push_back(mon_r);
    if (mon_r >= 0 && mon_r < 64) nd_log[mon_r] = div_nd;
  end

  int n_chk = 0;
  int n_pass = 0;

  // Reference model.
  int ec[$], ea[$];
  logic [SW-1:0] ed[$];
  int exp_empty;

  function automatic logic [SW-1:0] ref_coord(input int unsigned s, input int unsigned c);
    int unsigned q, r;
    q = s / c;
    r = s % c;
    if (ROUND && (2 * r >= c) && (q < (1 << SW) - 1)) q = q + 1;
    return q[SW-1:0];
  endfunction

  task automatic build_expected();
    ec.delete(); ea.delete(); ed.delete();
    exp_empty = 0;
    for (int k = 0; k < K; k++) if (cnts[k] == '0) exp_empty++;
    for (int i = 0; i < N; i++) begin
      if (cnts[i / D] != '0) begin
        ec.push_back(i + 2 + LAT);
        ea.push_back(i);
        ed.push_back(ref_coord(int'(sums[i]), int'(cnts[i / D])));
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic clear_logs();
    wr_c.delete(); wr_a.delete(); wr_d.delete(); done_c.delete();
    for (int i = 0; i < 64; i++) nd_log[i] = 1'bx;
  endtask

  // One pass: start in cycle 0, optional extra start pulses in cycles x1/x2.
  task automatic run_pass(input int x1, input int x2);
    clear_logs();
    base  = cyc;
    start = 1'b1;
    for (int r = 1; r <= PASS_CYC; r++) begin
      tick();
      start = (r == x1 || r == x2);
    end
    start = 1'b0;
  endtask

  task automatic test_reset();
    sclr = 1'b1; start = 1'b0;
    for (int i = 0; i < N; i++) sums[i] = '0;
    for (int k = 0; k < K; k++) cnts[k] = '0;
    repeat (3) tick();
    n_chk++; if (busy !== 1'b0) $display("FAIL rst_busy got %0b want 0", busy); else n_pass++;
    n_chk++; if (done !== 1'b0) $display("FAIL rst_done got %0b want 0", done); else n_pass++;
    n_chk++; if (cen_we !== 1'b0) $display("FAIL rst_cen_we got %0b want 0", cen_we); else n_pass++;
    n_chk++; if (div_nd !== 1'b0) $display("FAIL rst_div_nd got %0b want 0", div_nd); else n_pass++;
    n_chk++; if (empty_cnt !== 3'd0) $display("FAIL rst_empty_cnt got %0d want 0", empty_cnt); else n_pass++;
    n_chk++; if (rd_idx !== 3'd0) $display("FAIL rst_rd_idx got %0d want 0", rd_idx); else n_pass++;
    n_chk++; if (div_dividend !== '0) $display("FAIL rst_dividend got %0d want 0", div_dividend); else n_pass++;
    n_chk++; if (div_divisor !== 12'd1) $display("FAIL rst_divisor got %0d want 1", div_divisor); else n_pass++;
    n_chk++; if (cen_waddr !== 3'd0) $display("FAIL rst_waddr got %0d want 0", cen_waddr); else n_pass++;
    n_chk++; if (cen_wdata !== '0) $display("FAIL rst_wdata got %0d want 0", cen_wdata); else n_pass++;
    // Start on the very first edge after release; all clusters empty.
    sclr = 1'b0;
    clear_logs();
    base  = cyc;
    start = 1'b1;
    tick();
    start = 1'b0;
    n_chk++; if (busy !== 1'b1) $display("FAIL first_start_busy got %0b want 1", busy); else n_pass++;
    n_chk++; if (rd_idx !== 3'd0) $display("FAIL first_start_rd_idx got %0d want 0", rd_idx); else n_pass++;
    repeat (PASS_CYC) tick();
    n_chk++; if (wr_c.size() != 0) $display("FAIL all_empty_writes got %0d want 0", wr_c.size()); else n_pass++;
    n_chk++; if (done_c.size() != 1) $display("FAIL all_empty_done got %0d pulses want 1", done_c.size()); else n_pass++;
    n_chk++; if (empty_cnt !== 3'(K)) $display("FAIL all_empty_cnt got %0d want %0d", empty_cnt, K); else n_pass++;
  endtask

  task automatic test_basic();
    for (int i = 0; i < N; i++) sums[i] = SW'(100 * (i + 1));
    for (int k = 0; k < K; k++) cnts[k] = 12'd10;
    run_pass(-1, -1);
    n_chk++; if (wr_c.size() != N) $display("FAIL basic_nwr got %0d want %0d", wr_c.size(), N); else n_pass++;
    for (int i = 0; i < N && i < wr_c.size(); i++) begin
      n_chk++;
      if (wr_c[i] != i + 2 + LAT || wr_a[i] != i || wr_d[i] !== SW'(10 * (i + 1)))
        $display("FAIL basic_wr%0d got cyc %0d addr %0d data %0d want cyc %0d addr %0d data %0d",
                 i, wr_c[i], wr_a[i], wr_d[i], i + 2 + LAT, i, 10 * (i + 1));
      else n_pass++;
    end
    n_chk++;
    if (done_c.size() != 1 || done_c[0] != DONE_CYC)
      $display("FAIL basic_done got %0d pulses first at %0d want 1 at %0d",
               done_c.size(), (done_c.size() > 0) ? done_c[0] : -1, DONE_CYC);
    else n_pass++;
    n_chk++; if (empty_cnt !== 3'd0) $display("FAIL basic_empty got %0d want 0", empty_cnt); else n_pass++;
  endtask

  task automatic test_empty_cluster();
    for (int i = 0; i < N; i++) sums[i] = SW'($urandom_range(0, 100000));
    for (int k = 0; k < K; k++) cnts[k] = (k == 2) ? 12'd0 : CW'($urandom_range(1, 50));
    build_expected();
    run_pass(-1, -1);
    for (int r = 2; r < 2 + N; r++) begin
      n_chk++;
      if (nd_log[r] !== ((r - 2) / D != 2))
        $display("FAIL empty_nd cyc %0d got %0b want %0b", r, nd_log[r], ((r - 2) / D != 2));
      else n_pass++;
    end
    n_chk++; if (wr_c.size() != ec.size()) $display("FAIL empty_nwr got %0d want %0d", wr_c.size(), ec.size()); else n_pass++;
    for (int i = 0; i < wr_c.size() && i < ec.size(); i++) begin
      n_chk++;
      if (wr_c[i] != ec[i] || wr_a[i] != ea[i] || wr_d[i] !== ed[i])
        $display("FAIL empty_wr%0d got cyc %0d addr %0d data %0d want cyc %0d addr %0d data %0d",
                 i, wr_c[i], wr_a[i], wr_d[i], ec[i], ea[i], ed[i]);
      else n_pass++;
    end
    n_chk++; if (empty_cnt !== 3'd1) $display("FAIL empty_cnt got %0d want 1", empty_cnt); else n_pass++;
  endtask

  task automatic test_ignored_start();
    for (int i = 0; i < N; i++) sums[i] = SW'($urandom_range(1, 1000000));
    for (int k = 0; k < K; k++) cnts[k] = CW'($urandom_range(1, 4095));
    run_pass(3, 20);
    n_chk++; if (wr_c.size() != N) $display("FAIL ign_nwr got %0d want %0d", wr_c.size(), N); else n_pass++;
    n_chk++; if (done_c.size() != 1) $display("FAIL ign_ndone got %0d want 1", done_c.size()); else n_pass++;
  endtask

  task automatic test_sclr_abort();
    for (int i = 0; i < N; i++) sums[i] = SW'($urandom_range(1, 1000000));
    for (int k = 0; k < K; k++) cnts[k] = CW'($urandom_range(1, 100));
    clear_logs();
    base  = cyc;
    start = 1'b1;
    for (int r = 1; r <= 15; r++) begin
      tick();
      start = 1'b0;
    end
    sclr = 1'b1;
    #1;
    n_chk++; if (busy !== 1'b0) $display("FAIL abort_busy got %0b want 0", busy); else n_pass++;
    n_chk++; if (div_nd !== 1'b0) $display("FAIL abort_nd got %0b want 0", div_nd); else n_pass++;
    for (int r = 16; r <= 40; r++) begin
      tick();
      if (r == 16) sclr = 1'b0;
    end
    n_chk++; if (wr_c.size() != 0) $display("FAIL abort_writes got %0d want 0", wr_c.size()); else n_pass++;
    n_chk++; if (done_c.size() != 0) $display("FAIL abort_done got %0d want 0", done_c.size()); else n_pass++;
    build_expected();
    run_pass(-1, -1);
    n_chk++; if (wr_c.size() != ec.size()) $display("FAIL after_abort_nwr got %0d want %0d", wr_c.size(), ec.size()); else n_pass++;
    for (int i = 0; i < wr_c.size() && i < ec.size(); i++) begin
      n_chk++;
      if (wr_c[i] != ec[i] || wr_a[i] != ea[i] || wr_d[i] !== ed[i])
        $display("FAIL after_abort_wr%0d got cyc %0d addr %0d data %0d want cyc %0d addr %0d data %0d",
                 i, wr_c[i], wr_a[i], wr_d[i], ec[i], ea[i], ed[i]);
      else n_pass++;
    end
    n_chk++;
    if (done_c.size() != 1 || done_c[0] != DONE_CYC)
      $display("FAIL after_abort_done got %0d pulses want 1 at %0d", done_c.size(), DONE_CYC);
    else n_pass++;
  endtask

  task automatic test_round();
    logic [SW-1:0] want0;
    want0 = ROUND ? SW'(3) : SW'(2);
    for (int i = 0; i < N; i++) sums[i] = '0;
    for (int k = 0; k < K; k++) cnts[k] = '0;
    sums[0] = SW'(25);
    sums[1] = SW'(24);
    cnts[0] = 12'd10;
    run_pass(-1, -1);
    n_chk++; if (wr_c.size() != 2) $display("FAIL round_nwr got %0d want 2", wr_c.size()); else n_pass++;
    if (wr_c.size() == 2) begin
      n_chk++; if (wr_a[0] != 0 || wr_d[0] !== want0)
        $display("FAIL round_25_10 got addr %0d data %0d want addr 0 data %0d", wr_a[0], wr_d[0], want0);
      else n_pass++;
      n_chk++; if (wr_a[1] != 1 || wr_d[1] !== SW'(2))
        $display("FAIL round_24_10 got addr %0d data %0d want addr 1 data 2", wr_a[1], wr_d[1]);
      else n_pass++;
    end
    n_chk++; if (empty_cnt !== 3'd3) $display("FAIL round_empty got %0d want 3", empty_cnt); else n_pass++;
  endtask

  task automatic test_random();
    for (int p = 0; p < 6; p++) begin
      for (int i = 0; i < N; i++) sums[i] = SW'($urandom_range(0, (1 << SW) - 1));
      for (int k = 0; k < K; k++)
        cnts[k] = ($urandom_range(0, 3) == 0) ? 12'd0 :
                  (p[0] ? CW'($urandom_range(1, 20)) : CW'($urandom_range(1, 4095)));
      build_expected();
      run_pass(-1, -1);
      n_chk++; if (wr_c.size() != ec.size()) $display("FAIL rnd%0d_nwr got %0d want %0d", p, wr_c.size(), ec.size()); else n_pass++;
      for (int i = 0; i < wr_c.size() && i < ec.size(); i++) begin
        n_chk++;
        if (wr_c[i] != ec[i] || wr_a[i] != ea[i] || wr_d[i] !== ed[i])
          $display("FAIL rnd%0d_wr%0d got cyc %0d addr %0d data %0d want cyc %0d addr %0d data %0d",
                   p, i, wr_c[i], wr_a[i], wr_d[i], ec[i], ea[i], ed[i]);
        else n_pass++;
      end
      n_chk++; if (empty_cnt !== 3'(exp_empty)) $display("FAIL rnd%0d_empty got %0d want %0d", p, empty_cnt, exp_empty); else n_pass++;
      n_chk++;
      if (done_c.size() != 1 || done_c[0] != DONE_CYC)
        $display("FAIL rnd%0d_done got %0d pulses want 1 at %0d", p, done_c.size(), DONE_CYC);
      else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_empty_cluster();
    test_ignored_start();
    test_sclr_abort();
    test_round();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
